// File: rtl/rf_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  rf_pkg
//  Shared constants, entry type and source encoding for the RF write scheduler.
//  Revision: 1.0
// ============================================================================
package rf_pkg;

    localparam int DataWidth  = 32;
    localparam int IndexWidth = 5;
    localparam int NumRegs    = 32;
    localparam int Depth      = 2;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } src_t;

    typedef struct packed {
        logic [IndexWidth-1:0] addr;
        logic [DataWidth-1:0]  data;
    } wb_entry_t;

    // r0 is hardwired and out-of-range indices have no backing register
    function automatic logic addrWritable(input logic [IndexWidth-1:0] addr);
        return (addr != '0) && (32'(addr) < 32'(NumRegs));
    endfunction

endpackage
`default_nettype wire

// File: rtl/rf_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  rf_wb_arbiter_if
//  Source handshakes, register-file write port and hazard query bundle.
//  Revision: 1.0
// ============================================================================
interface rf_wb_arbiter_if;
    import rf_pkg::*;

    logic                  src0Valid;
    logic [IndexWidth-1:0] src0Addr;
    logic [DataWidth-1:0]  src0Data;
    logic                  src0Ready;
    logic                  src1Valid;
    logic [IndexWidth-1:0] src1Addr;
    logic [DataWidth-1:0]  src1Data;
    logic                  src1Ready;
    logic                  writeEn;
    logic [IndexWidth-1:0] writeAddr;
    logic [DataWidth-1:0]  writeData;
    logic [IndexWidth-1:0] readAddr1;
    logic [IndexWidth-1:0] readAddr2;
    logic                  hazard1;
    logic                  hazard2;

    modport master (
        output src0Valid, src0Addr, src0Data, src1Valid, src1Addr, src1Data,
        output readAddr1, readAddr2,
        input  src0Ready, src1Ready, writeEn, writeAddr, writeData, hazard1, hazard2
    );

    modport slave (
        input  src0Valid, src0Addr, src0Data, src1Valid, src1Addr, src1Data,
        input  readAddr1, readAddr2,
        output src0Ready, src1Ready, writeEn, writeAddr, writeData, hazard1, hazard2
    );

endinterface
`default_nettype wire

// File: rtl/rf_wb_arbiter_fifo.sv
`default_nettype none
// ============================================================================
//  rf_wb_fifo
//  Two-entry writeback buffer; slot 0 is always the head, all slots visible.
//  Revision: 1.0
// ============================================================================
module rf_wb_fifo
    import rf_pkg::*;
(
    input  wire logic                  clk,
    input  wire logic                  rstn,
    input  wire logic                  push,
    input  wire wb_entry_t             pushEntry,
    input  wire logic                  pop,
    output logic                       full,
    output logic                       empty,
    output wb_entry_t                  head,
    output wb_entry_t [Depth-1:0]      entries,
    output logic      [Depth-1:0]      entryValid
);

    wb_entry_t [Depth-1:0] r_slot;
    logic      [1:0]       r_count;
    logic                  w_doPush;
    logic                  w_doPop;

    assign full       = (r_count == 2'd2);
    assign empty      = (r_count == 2'd0);
    assign w_doPush   = push & ~full;
    assign w_doPop    = pop & ~empty;
    assign head       = r_slot[0];
    assign entries    = r_slot;
    assign entryValid = {r_count == 2'd2, r_count != 2'd0};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_slot  <= '0;
            r_count <= 2'd0;
        end else begin
            if (w_doPop) begin
                // Full pop shifts the tail forward; single-entry pop may refill in place
                if (r_count == 2'd2)
                    r_slot[0] <= r_slot[1];
                else if (w_doPush)
                    r_slot[0] <= pushEntry;
            end else if (w_doPush) begin
                if (r_count == 2'd0)
                    r_slot[0] <= pushEntry;
                else
                    r_slot[1] <= pushEntry;
            end
            r_count <= r_count + 2'(w_doPush) - 2'(w_doPop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  rf_wb_arbiter
//  Round-robin scheduler of two writeback sources onto the RF write port.
//  Revision: 1.0
// ============================================================================
module rf_wb_arbiter
    import rf_pkg::*;
(
    input  wire logic      clk,
    input  wire logic      rstn,
    rf_wb_arbiter_if.slave bus
);

    logic      [1:0]           w_srcValid;
    wb_entry_t                 w_srcEntry   [2];
    logic      [1:0]           w_full;
    logic      [1:0]           w_empty;
    logic      [1:0]           w_pop;
    wb_entry_t                 w_head       [2];
    wb_entry_t [Depth-1:0]     w_entries    [2];
    logic      [Depth-1:0]     w_entryValid [2];

    logic                      w_grantValid;
    src_t                      w_grantSrc;
    wb_entry_t                 w_grantEntry;
    logic [IndexWidth-1:0]     w_rd [2];
    logic [1:0]                w_hazard;

    src_t                      r_prefer;
    logic                      r_writeEn;
    logic [IndexWidth-1:0]     r_writeAddr;
    logic [DataWidth-1:0]      r_writeData;

    assign w_srcValid = {bus.src1Valid, bus.src0Valid};
    assign w_srcEntry[SRC_ALU] = '{addr: bus.src0Addr, data: bus.src0Data};
    assign w_srcEntry[SRC_LSU] = '{addr: bus.src1Addr, data: bus.src1Data};

    generate
        for (genvar i = 0; i < 2; i++) begin : g_fifo
            rf_wb_fifo u_fifo (
                .clk        (clk),
                .rstn       (rstn),
                .push       (w_srcValid[i]),
                .pushEntry  (w_srcEntry[i]),
                .pop        (w_pop[i]),
                .full       (w_full[i]),
                .empty      (w_empty[i]),
                .head       (w_head[i]),
                .entries    (w_entries[i]),
                .entryValid (w_entryValid[i])
            );
        end
    endgenerate

    always_comb begin
        w_grantValid = ~w_empty[SRC_ALU] | ~w_empty[SRC_LSU];
        if (w_empty[SRC_ALU])
            w_grantSrc = SRC_LSU;
        else if (w_empty[SRC_LSU])
            w_grantSrc = SRC_ALU;
        else
            w_grantSrc = r_prefer;
        w_grantEntry = w_head[w_grantSrc];
        w_pop        = 2'b00;
        if (w_grantValid)
            w_pop = (w_grantSrc == SRC_LSU) ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_prefer    <= SRC_ALU;
            r_writeEn   <= 1'b0;
            r_writeAddr <= '0;
            r_writeData <= '0;
        end else begin
            r_writeEn <= 1'b0;
            if (w_grantValid) begin
                r_prefer    <= (w_grantSrc == SRC_ALU) ? SRC_LSU : SRC_ALU;
                // Dropped writes still load the stage so the grant is visibly consumed
                r_writeEn   <= addrWritable(w_grantEntry.addr);
                r_writeAddr <= w_grantEntry.addr;
                r_writeData <= w_grantEntry.data;
            end
        end
    end

    assign w_rd[0] = bus.readAddr1;
    assign w_rd[1] = bus.readAddr2;

    always_comb begin
        w_hazard = 2'b00;
        for (int k = 0; k < 2; k++) begin
            if (r_writeEn && (r_writeAddr == w_rd[k]))
                w_hazard[k] = 1'b1;
            for (int s = 0; s < 2; s++) begin
                for (int e = 0; e < Depth; e++) begin
                    if (w_entryValid[s][e] && (w_entries[s][e].addr == w_rd[k]))
                        w_hazard[k] = 1'b1;
                end
            end
            if (w_rd[k] == '0)
                w_hazard[k] = 1'b0;
        end
    end

    assign bus.src0Ready = ~w_full[SRC_ALU];
    assign bus.src1Ready = ~w_full[SRC_LSU];
    assign bus.writeEn   = r_writeEn;
    assign bus.writeAddr = r_writeAddr;
    assign bus.writeData = r_writeData;
    assign bus.hazard1   = w_hazard[0];
    assign bus.hazard2   = w_hazard[1];

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  tb_rf_wb_arbiter
//  Directed scoreboard bench for the RF writeback arbiter.
//  Revision: 1.0
// ============================================================================
module tb_rf_wb_arbiter;
    import rf_pkg::*;

    logic clk = 1'b0;
    logic rstn;
    int   checks = 0;
    int   errors = 0;
    wb_entry_t expQ[$];
    logic [9:0] weHist;

    rf_wb_arbiter_if bus ();

    rf_wb_arbiter dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic expWrite(input logic [IndexWidth-1:0] a, input logic [DataWidth-1:0] d);
        wb_entry_t e;
        e.addr = a;
        e.data = d;
        expQ.push_back(e);
    endtask

    task automatic step(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                        input logic v1, input logic [4:0] a1, input logic [31:0] d1);
        bus.src0Valid = v0;
        bus.src0Addr  = a0;
        bus.src0Data  = d0;
        bus.src1Valid = v1;
        bus.src1Addr  = a1;
        bus.src1Data  = d1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    // Scoreboard monitor: every write the register file sees must be the next expected one
    always @(negedge clk) begin
        wb_entry_t e;
        if (rstn === 1'b1 && bus.writeEn === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected write: got addr %0d data 0x%08h expected no write",
                         bus.writeAddr, bus.writeData);
            end else begin
                e = expQ.pop_front();
                chk("write addr", 32'(bus.writeAddr), 32'(e.addr));
                chk("write data", bus.writeData, e.data);
            end
        end
    end

    initial begin
        rstn          = 1'b0;
        bus.readAddr1 = 5'd5;
        bus.readAddr2 = 5'd0;
        bus.src0Valid = 1'b0;
        bus.src0Addr  = '0;
        bus.src0Data  = '0;
        bus.src1Valid = 1'b0;
        bus.src1Addr  = '0;
        bus.src1Data  = '0;
        @(negedge clk);
        @(negedge clk);

        chk("reset writeEn",   32'(bus.writeEn),   32'd0);
        chk("reset writeAddr", 32'(bus.writeAddr), 32'd0);
        chk("reset writeData", bus.writeData,      32'd0);
        chk("reset src0Ready", 32'(bus.src0Ready), 32'd1);
        chk("reset src1Ready", 32'(bus.src1Ready), 32'd1);
        chk("reset hazard1",   32'(bus.hazard1),   32'd0);
        rstn = 1'b1;

        // Single src0 write to r5
        expWrite(5'd5, 32'hDEADBEEF);
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
        chk("t1 hazard1 after accept", 32'(bus.hazard1), 32'd1);
        chk("t1 writeEn before load",  32'(bus.writeEn), 32'd0);
        idle(1);
        chk("t1 writeEn after load",   32'(bus.writeEn), 32'd1);
        chk("t1 hazard1 during write", 32'(bus.hazard1), 32'd1);
        idle(1);
        chk("t1 hazard1 after write",  32'(bus.hazard1), 32'd0);
        chk("t1 writeEn after write",  32'(bus.writeEn), 32'd0);

        // Both sources streaming; pointer prefers src1 after the lone src0 grant
        expWrite(5'd20, 32'hB000_0000);
        expWrite(5'd10, 32'hA000_0000);
        expWrite(5'd21, 32'hB000_0001);
        expWrite(5'd11, 32'hA000_0001);
        expWrite(5'd22, 32'hB000_0002);
        expWrite(5'd12, 32'hA000_0002);
        expWrite(5'd23, 32'hB000_0003);
        expWrite(5'd13, 32'hA000_0003);
        weHist = '0;
        step(1'b1, 5'd10, 32'hA000_0000, 1'b1, 5'd20, 32'hB000_0000); weHist = {weHist[8:0], bus.writeEn};
        step(1'b1, 5'd11, 32'hA000_0001, 1'b1, 5'd21, 32'hB000_0001); weHist = {weHist[8:0], bus.writeEn};
        chk("t2 src0Ready full", 32'(bus.src0Ready), 32'd0);
        step(1'b1, 5'd12, 32'hA000_0002, 1'b1, 5'd22, 32'hB000_0002); weHist = {weHist[8:0], bus.writeEn};
        chk("t2 src1Ready full", 32'(bus.src1Ready), 32'd0);
        chk("t2 src0Ready back", 32'(bus.src0Ready), 32'd1);
        step(1'b1, 5'd12, 32'hA000_0002, 1'b1, 5'd23, 32'hB000_0003); weHist = {weHist[8:0], bus.writeEn};
        chk("t2 src0Ready refull", 32'(bus.src0Ready), 32'd0);
        step(1'b1, 5'd13, 32'hA000_0003, 1'b1, 5'd23, 32'hB000_0003); weHist = {weHist[8:0], bus.writeEn};
        step(1'b1, 5'd13, 32'hA000_0003, 1'b0, 5'd0,  32'h0);         weHist = {weHist[8:0], bus.writeEn};
        for (int i = 0; i < 4; i++) begin
            idle(1);
            weHist = {weHist[8:0], bus.writeEn};
        end
        chk("t2 writeEn pattern", 32'(weHist), 32'b0111111110);

        // Write to r0 consumes a grant but never enables the port
        bus.readAddr1 = 5'd0;
        step(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0);
        chk("t3 hazard1 r0 queued", 32'(bus.hazard1),   32'd0);
        idle(1);
        chk("t3 writeEn r0",        32'(bus.writeEn),   32'd0);
        chk("t3 writeAddr r0",      32'(bus.writeAddr), 32'd0);
        chk("t3 writeData r0",      bus.writeData,      32'hFFFF_FFFF);
        chk("t3 hazard1 r0 loaded", 32'(bus.hazard1),   32'd0);

        // src1 fills while src0 competes; blocked push to r7 must vanish
        bus.readAddr1 = 5'd6;
        bus.readAddr2 = 5'd7;
        expWrite(5'd4, 32'hD000_0000);
        expWrite(5'd1, 32'hC000_0000);
        expWrite(5'd5, 32'hD000_0001);
        expWrite(5'd2, 32'hC000_0001);
        expWrite(5'd6, 32'hD000_0002);
        expWrite(5'd3, 32'hC000_0002);
        step(1'b1, 5'd1, 32'hC000_0000, 1'b1, 5'd4, 32'hD000_0000);
        step(1'b1, 5'd2, 32'hC000_0001, 1'b1, 5'd5, 32'hD000_0001);
        step(1'b0, 5'd0, 32'h0,         1'b1, 5'd6, 32'hD000_0002);
        chk("t4 src1Ready full",   32'(bus.src1Ready), 32'd0);
        chk("t4 hazard1 r6 queued", 32'(bus.hazard1),  32'd1);
        step(1'b1, 5'd3, 32'hC000_0002, 1'b1, 5'd7, 32'hDEAD_0007);
        chk("t4 src1Ready freed",  32'(bus.src1Ready), 32'd1);
        chk("t4 hazard2 dropped push", 32'(bus.hazard2), 32'd0);
        idle(5);

        // Same register from both sources with pointer preferring src0
        expWrite(5'd8, 32'h0000_0088);
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 32'h0000_0088);
        idle(2);
        bus.readAddr1 = 5'd7;
        expWrite(5'd7, 32'h0000_0000);
        expWrite(5'd7, 32'h0000_0001);
        step(1'b1, 5'd7, 32'h0000_0000, 1'b1, 5'd7, 32'h0000_0001);
        chk("t5 hazard1 r7 queued", 32'(bus.hazard1), 32'd1);
        idle(4);
        chk("t5 final writeData",   bus.writeData,    32'h0000_0001);
        chk("t5 hazard1 r7 done",   32'(bus.hazard1), 32'd0);

        // Asynchronous reset with entries in flight and a write on the port
        bus.readAddr1 = 5'd13;
        expWrite(5'd11, 32'hE000_0000);
        step(1'b1, 5'd11, 32'hE000_0000, 1'b1, 5'd12, 32'hF000_0000);
        step(1'b1, 5'd13, 32'hE000_0001, 1'b1, 5'd14, 32'hF000_0001);
        bus.src0Valid = 1'b1;
        bus.src0Addr  = 5'd15;
        bus.src0Data  = 32'hE000_0002;
        bus.src1Valid = 1'b1;
        bus.src1Addr  = 5'd16;
        bus.src1Data  = 32'hF000_0002;
        @(posedge clk);
        #2;
        chk("t6 writeEn before reset",   32'(bus.writeEn),   32'd1);
        chk("t6 hazard1 before reset",   32'(bus.hazard1),   32'd1);
        chk("t6 src0Ready before reset", 32'(bus.src0Ready), 32'd0);
        rstn          = 1'b0;
        bus.src0Valid = 1'b0;
        bus.src1Valid = 1'b0;
        #1;
        chk("t6 reset writeEn",   32'(bus.writeEn),   32'd0);
        chk("t6 reset writeAddr", 32'(bus.writeAddr), 32'd0);
        chk("t6 reset writeData", bus.writeData,      32'd0);
        chk("t6 reset src0Ready", 32'(bus.src0Ready), 32'd1);
        chk("t6 reset src1Ready", 32'(bus.src1Ready), 32'd1);
        chk("t6 reset hazard1",   32'(bus.hazard1),   32'd0);
        @(negedge clk);
        rstn = 1'b1;
        idle(5);
        chk("t6 src0Ready after release", 32'(bus.src0Ready), 32'd1);
        chk("t6 src1Ready after release", 32'(bus.src1Ready), 32'd1);
        chk("scoreboard drained", 32'(expQ.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
